// File: rtl/conv_share_arbiter.sv
// Round-robin share of one 4-bit binary<->Gray converter between two requesters.
// Optional per-requester completion counters enabled by defining CONV_OP_COUNT_EN.
module conv_share_arbiter #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] mode,
  input  logic [3:0] din0,
  input  logic [3:0] din1,
  output logic [1:0] ack,
  output logic [3:0] dout,
  output logic       busy,
  output logic       owner
`ifdef CONV_OP_COUNT_EN
  ,
  output logic [7:0] cnt0,
  output logic [7:0] cnt1
`endif
);

  typedef enum logic [1:0] {StIdle, StSettle, StDone} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q;
  logic [3:0] op_q;
  logic       mode_q;
  logic       last_q;
  logic       owner_q;
  logic [1:0] ack_q;
  logic [3:0] dout_q;

  logic       grant;
  logic       grant_idx;
  logic       capture;
  logic [3:0] b2g;
  logic [3:0] g2b;
  logic [3:0] conv_res;

  // On a tie the requester that was not served last wins.
  assign grant_idx = (req == 2'b11) ? ~last_q : req[1];

  // Converter only ever sees the latched operand.
  assign b2g      = op_q ^ {1'b0, op_q[3:1]};
  assign g2b[3]   = op_q[3];
  assign g2b[2]   = g2b[3] ^ op_q[2];
  assign g2b[1]   = g2b[2] ^ op_q[1];
  assign g2b[0]   = g2b[1] ^ op_q[0];
  assign conv_res = mode_q ? g2b : b2g;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req != 2'b00) state_d = StSettle;
      StSettle: if (cnt_q == 4'd0) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    grant   = 1'b0;
    capture = 1'b0;
    busy    = 1'b0;
    unique case (state_q)
      StIdle:   grant = (req != 2'b00);
      StSettle: begin
        busy    = 1'b1;
        capture = (cnt_q == 4'd0);
      end
      StDone:   busy = 1'b1;
      default:  busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
      mode_q  <= 1'b0;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      ack_q   <= 2'b00;
      dout_q  <= 4'd0;
    end else begin
      ack_q <= 2'b00;
      if (grant) begin
        op_q    <= grant_idx ? din1 : din0;
        mode_q  <= mode[grant_idx];
        owner_q <= grant_idx;
        last_q  <= grant_idx;
        cnt_q   <= 4'(SETTLE_CYC - 1);
      end else if (capture) begin
        dout_q <= conv_res;
        ack_q  <= owner_q ? 2'b10 : 2'b01;
      end else if (state_q == StSettle) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  assign ack   = ack_q;
  assign dout  = dout_q;
  assign owner = owner_q;

`ifdef CONV_OP_COUNT_EN
  logic [7:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= 8'd0;
      cnt1_q <= 8'd0;
    end else if (capture) begin
      if (!owner_q && cnt0_q != 8'hff) cnt0_q <= cnt0_q + 8'd1;
      if (owner_q && cnt1_q != 8'hff)  cnt1_q <= cnt1_q + 8'd1;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_conv_share_arbiter.sv
// Scoreboard bench for conv_share_arbiter: stimulus pushes expected acks, a monitor checks them.
module tb_conv_share_arbiter;

  localparam int unsigned SettleCyc = 2;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] mode;
  logic [3:0] din0;
  logic [3:0] din1;
  logic [1:0] ack;
  logic [3:0] dout;
  logic       busy;
  logic       owner;
`ifdef CONV_OP_COUNT_EN
  logic [7:0] cnt0;
  logic [7:0] cnt1;
`endif

  conv_share_arbiter #(.SETTLE_CYC(SettleCyc)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .mode  (mode),
    .din0  (din0),
    .din1  (din1),
    .ack   (ack),
    .dout  (dout),
    .busy  (busy),
    .owner (owner)
`ifdef CONV_OP_COUNT_EN
    ,
    .cnt0  (cnt0),
    .cnt1  (cnt1)
`endif
  );

  typedef struct {
    logic [1:0] ack;
    logic [3:0] dout;
    logic       owner;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] from_gray(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Monitor: every ack pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (rst_n && ack != 2'b00) begin
      if (sbq.size() == 0) begin
        chk("unexpected_ack", {30'd0, ack}, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_ack", {30'd0, ack}, {30'd0, e.ack});
        chk("sb_dout", {28'd0, dout}, {28'd0, e.dout});
        chk("sb_owner", {31'd0, owner}, {31'd0, e.owner});
      end
    end
  end

  // Issue one request at a negedge, wait for its ack, drop req in the ack cycle.
  task automatic do_op(input int idx, input logic m, input logic [3:0] d, input logic [3:0] exp_d,
                       input bit chk_lat);
    int cyc;
    exp_t e;
    if (idx == 0) begin
      din0    = d;
      mode[0] = m;
    end else begin
      din1    = d;
      mode[1] = m;
    end
    e.ack   = (idx == 0) ? 2'b01 : 2'b10;
    e.dout  = exp_d;
    e.owner = (idx != 0);
    sbq.push_back(e);
    req[idx] = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (ack[idx] !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 40) chk("ack_timeout", 32'(cyc), 32'd0);
    if (chk_lat) chk("latency", 32'(cyc), 32'(SettleCyc));
    req[idx] = 1'b0;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int t0;
    int t1;
    int cyc;
    rst_n = 1'b0;
    req   = 2'b00;
    mode  = 2'b00;
    din0  = 4'd0;
    din1  = 4'd0;
    apply_reset();

    chk("rst_ack", {30'd0, ack}, 32'd0);
    chk("rst_dout", {28'd0, dout}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_owner", {31'd0, owner}, 32'd0);

    // Single op with explicit busy window k+1..k+3.
    din0 = 4'b1011;
    mode = 2'b00;
    sbq.push_back('{ack: 2'b01, dout: 4'b1110, owner: 1'b0});
    req = 2'b01;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("busy_window", {31'd0, busy}, 32'd1);
      chk("ack_timing", {30'd0, ack}, (c == 3) ? 32'd1 : 32'd0);
    end
    req = 2'b00;
    @(negedge clk);
    chk("busy_after_done", {31'd0, busy}, 32'd0);

    do_op(1, 1'b1, 4'b1110, 4'b1011, 1'b1);
    do_op(1, 1'b1, 4'b1000, 4'b1111, 1'b1);

    // Tie right after reset: requester 0 first, then 1, acks 4 cycles apart.
    apply_reset();
    mode = 2'b10;
    din0 = 4'b0011;
    din1 = 4'b0110;
    sbq.push_back('{ack: 2'b01, dout: 4'b0010, owner: 1'b0});
    sbq.push_back('{ack: 2'b10, dout: 4'b0100, owner: 1'b1});
    req = 2'b11;
    cyc = 0;
    t0  = 0;
    t1  = 0;
    while (cyc < 40 && t1 == 0) begin
      @(negedge clk);
      cyc++;
      if (ack[0] === 1'b1) begin
        t0     = cyc;
        req[0] = 1'b0;
      end
      if (ack[1] === 1'b1) begin
        t1     = cyc;
        req[1] = 1'b0;
      end
    end
    chk("tie_first_latency", 32'(t0), 32'(SettleCyc + 1));
    chk("tie_ack_spacing", 32'(t1 - t0), 32'(SettleCyc + 2));
    @(negedge clk);

    // Operand latched at grant; later din0 change must not affect the result.
    din0    = 4'b0101;
    mode[0] = 1'b0;
    sbq.push_back('{ack: 2'b01, dout: 4'b0111, owner: 1'b0});
    req[0] = 1'b1;
    @(negedge clk);
    din0 = 4'b1111;
    cyc  = 0;
    while (ack[0] !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    req[0] = 1'b0;
    @(negedge clk);

    // Reset in SETTLE clears everything immediately and suppresses the ack.
    din1    = 4'b1011;
    mode[1] = 1'b0;
    req[1]  = 1'b1;
    @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ack", {30'd0, ack}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_dout", {28'd0, dout}, 32'd0);
    chk("midrst_owner", {31'd0, owner}, 32'd0);
    req = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // Full sweeps of both conversion directions.
    for (int v = 0; v < 16; v++) do_op(0, 1'b0, 4'(v), to_gray(4'(v)), 1'b0);
    for (int v = 0; v < 16; v++) do_op(1, 1'b1, 4'(v), from_gray(4'(v)), 1'b0);
`ifdef CONV_OP_COUNT_EN
    chk("cnt0_sweep", {24'd0, cnt0}, 32'd16);
    chk("cnt1_sweep", {24'd0, cnt1}, 32'd16);
`endif
    for (int n = 0; n < 300; n++) do_op(0, 1'b0, 4'(n), to_gray(4'(n)), 1'b0);
`ifdef CONV_OP_COUNT_EN
    chk("cnt0_saturate", {24'd0, cnt0}, 32'd255);
    chk("cnt1_hold", {24'd0, cnt1}, 32'd16);
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
